// File: rtl/noc_credit_input_buffer_if.sv
// ---------------------------------------------------------------------------
// noc_credit_input_buffer_if
// Link bundle around the NoC credit input buffer.
//   Upstream side  : data_in, dest_in, is_tail_in, send_in -> buffer
//                    credit_out                           <- buffer
//   Consumer side  : flit_valid, flit_data, flit_dest,
//                    flit_is_head, flit_is_tail            <- buffer
//                    flit_ready                           -> buffer
// Modports: slave  = the buffer itself
//           master = the environment (upstream router + local consumer)
// ---------------------------------------------------------------------------
interface noc_credit_input_buffer_if #(
   parameter int unsigned TDEST_WIDTH = 3,
   parameter int unsigned FLIT_WIDTH  = 128
);

   logic [FLIT_WIDTH-1:0]  data_in;
   logic [TDEST_WIDTH-1:0] dest_in;
   logic                   is_tail_in;
   logic                   send_in;
   logic                   credit_out;

   logic                   flit_valid;
   logic                   flit_ready;
   logic [FLIT_WIDTH-1:0]  flit_data;
   logic [TDEST_WIDTH-1:0] flit_dest;
   logic                   flit_is_head;
   logic                   flit_is_tail;

   modport slave (
      input  data_in, dest_in, is_tail_in, send_in, flit_ready,
      output credit_out, flit_valid, flit_data, flit_dest,
             flit_is_head, flit_is_tail
   );

   modport master (
      output data_in, dest_in, is_tail_in, send_in, flit_ready,
      input  credit_out, flit_valid, flit_data, flit_dest,
             flit_is_head, flit_is_tail
   );

endinterface

// File: rtl/noc_credit_input_buffer.sv
// ---------------------------------------------------------------------------
// noc_credit_input_buffer
// Credit-flow-controlled flit FIFO at a NoC router input. Upstream may send
// one flit per credit; each dequeued flit returns one credit one cycle later.
// The head of the queue is presented show-ahead, and a two-state packet FSM
// marks head flits and pins the destination for the whole packet.
//
// Ports:
//   clk_noc        : sole clock, all state on rising edge
//   rst_n_noc_sync : asynchronous active-low reset
//   bus            : noc_credit_input_buffer_if.slave (flit in/out, credits)
//   overflow_err   : sticky overflow flag, only when
//                    NOC_INBUF_OVERFLOW_CHECK_EN is defined
//
// Build option: `define NOC_INBUF_OVERFLOW_CHECK_EN adds overflow_err.
// FLIT_BUFFER_DEPTH must be a power of two >= 2 (pointers wrap naturally).
// ---------------------------------------------------------------------------
module noc_credit_input_buffer #(
   parameter int unsigned TDEST_WIDTH       = 3,
   parameter int unsigned FLIT_WIDTH        = 128,
   parameter int unsigned FLIT_BUFFER_DEPTH = 4
) (
   input  logic                      clk_noc,
   input  logic                      rst_n_noc_sync,
   noc_credit_input_buffer_if.slave  bus
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
   ,
   output logic                      overflow_err
`endif
);

   localparam int unsigned PTR_W = $clog2(FLIT_BUFFER_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [FLIT_WIDTH-1:0]  data;
      logic [TDEST_WIDTH-1:0] dest;
      logic                   tail;
   } entry_t;

   typedef enum logic {
      ST_HEAD = 1'b0,
      ST_BODY = 1'b1
   } state_t;

   entry_t                 mem_q [FLIT_BUFFER_DEPTH];
   entry_t                 head_entry;
   logic [PTR_W-1:0]       wr_ptr_q;
   logic [PTR_W-1:0]       rd_ptr_q;
   logic [CNT_W-1:0]       occ_q;
   logic [TDEST_WIDTH-1:0] dest_lat_q;
   logic                   credit_q;
   state_t                 state_q;
   state_t                 state_d;

   logic                   flit_valid;
   logic                   deq;
   logic                   full;
   logic                   wr_en;

   // Queue status and handshake qualification
   assign head_entry = mem_q[rd_ptr_q];
   assign flit_valid = (occ_q != '0);
   assign deq        = flit_valid & bus.flit_ready;
   assign full       = (occ_q == CNT_W'(FLIT_BUFFER_DEPTH));
   // A write into a full buffer is still legal when a slot frees this cycle
   assign wr_en      = bus.send_in & (~full | deq);

   // Storage array, deliberately not reset
   always_ff @(posedge clk_noc) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= '{data: bus.data_in, dest: bus.dest_in,
                              tail: bus.is_tail_in};
      end
   end

   // Pointers, occupancy, credit return, packet destination latch
   always_ff @(posedge clk_noc or negedge rst_n_noc_sync) begin
      if (!rst_n_noc_sync) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         occ_q      <= '0;
         credit_q   <= 1'b0;
         dest_lat_q <= '0;
      end else begin
         credit_q <= deq;
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (deq) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (wr_en && !deq) begin
            occ_q <= occ_q + CNT_W'(1);
         end else if (!wr_en && deq) begin
            occ_q <= occ_q - CNT_W'(1);
         end
         if (deq && (state_q == ST_HEAD)) begin
            dest_lat_q <= head_entry.dest;
         end
      end
   end

   // Packet FSM: state register
   always_ff @(posedge clk_noc or negedge rst_n_noc_sync) begin
      if (!rst_n_noc_sync) begin
         state_q <= ST_HEAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Packet FSM: next state, advanced only by dequeues
   always_comb begin
      state_d = state_q;
      if (deq) begin
         case (state_q)
            ST_HEAD: if (!head_entry.tail) state_d = ST_BODY;
            ST_BODY: if (head_entry.tail)  state_d = ST_HEAD;
            default: state_d = ST_HEAD;
         endcase
      end
   end

   // Packet FSM: outputs; body flits reuse the destination of their head
   always_comb begin
      bus.flit_is_head = 1'b0;
      bus.flit_dest    = dest_lat_q;
      if (state_q == ST_HEAD) begin
         bus.flit_is_head = flit_valid;
         bus.flit_dest    = head_entry.dest;
      end
   end

   assign bus.flit_valid   = flit_valid;
   assign bus.flit_data    = head_entry.data;
   assign bus.flit_is_tail = head_entry.tail;
   assign bus.credit_out   = credit_q;

`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
   logic overflow;
   logic overflow_q;

   // Flit arriving with no free slot and no slot freeing this cycle
   assign overflow = bus.send_in & full & ~deq;

   always_ff @(posedge clk_noc or negedge rst_n_noc_sync) begin
      if (!rst_n_noc_sync) begin
         overflow_q <= 1'b0;
      end else if (overflow) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow_err = overflow_q;
`endif

endmodule

// File: tb/tb_noc_credit_input_buffer.sv
// ---------------------------------------------------------------------------
// tb_noc_credit_input_buffer
// Directed bench for noc_credit_input_buffer (DEPTH 4, 128-bit flits,
// 3-bit dest). Inputs change and outputs are sampled 1 time unit after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_noc_credit_input_buffer;

   localparam int unsigned TW = 3;
   localparam int unsigned FW = 128;
   localparam int unsigned DEPTH = 4;

   logic clk_noc = 1'b0;
   logic rst_n   = 1'b0;
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
   logic overflow_err;
`endif

   int n_cmp = 0;
   int n_err = 0;

   noc_credit_input_buffer_if #(.TDEST_WIDTH(TW), .FLIT_WIDTH(FW)) bus ();

   noc_credit_input_buffer #(
      .TDEST_WIDTH       (TW),
      .FLIT_WIDTH        (FW),
      .FLIT_BUFFER_DEPTH (DEPTH)
   ) dut (
      .clk_noc        (clk_noc),
      .rst_n_noc_sync (rst_n),
      .bus            (bus)
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
      ,
      .overflow_err   (overflow_err)
`endif
   );

   always #5 clk_noc = ~clk_noc;

   task automatic step();
      @(posedge clk_noc);
      #1;
   endtask

   task automatic check_w(input string tag, input logic [127:0] obs,
                          input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [127:0] d, input logic [2:0] dst,
                       input logic tl);
      bus.send_in    = 1'b1;
      bus.data_in    = d;
      bus.dest_in    = dst;
      bus.is_tail_in = tl;
   endtask

   logic [127:0] exp_q[$];
   logic [127:0] d;
   int credits, sent, deq_n, cred_n;
   logic do_send;

   initial begin
      bus.send_in    = 1'b0;
      bus.data_in    = '0;
      bus.dest_in    = '0;
      bus.is_tail_in = 1'b0;
      bus.flit_ready = 1'b0;

      // Reset state
      step();
      step();
      check_b("rst_valid", bus.flit_valid, 1'b0);
      check_b("rst_head", bus.flit_is_head, 1'b0);
      check_b("rst_credit", bus.credit_out, 1'b0);
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
      check_b("rst_ovf", overflow_err, 1'b0);
`endif
      rst_n = 1'b1;
      step();

      // Single-flit packet, dest 5
      bus.flit_ready = 1'b1;
      send(128'hA5A5_0001, 3'd5, 1'b1);
      check_b("single_nobypass", bus.flit_valid, 1'b0);
      step();
      bus.send_in = 1'b0;
      check_b("single_valid", bus.flit_valid, 1'b1);
      check_b("single_head", bus.flit_is_head, 1'b1);
      check_b("single_tail", bus.flit_is_tail, 1'b1);
      check_w("single_dest", 128'(bus.flit_dest), 128'(5));
      check_w("single_data", bus.flit_data, 128'hA5A5_0001);
      check_b("single_credit_early", bus.credit_out, 1'b0);
      step();
      check_b("single_credit", bus.credit_out, 1'b1);
      check_b("single_empty", bus.flit_valid, 1'b0);
      step();
      check_b("single_credit_end", bus.credit_out, 1'b0);

      // 4-flit packet, dest_in 2,7,7,7, held then drained
      bus.flit_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(128'hB000 + 128'(i), (i == 0) ? 3'd2 : 3'd7, (i == 3));
         step();
      end
      bus.send_in = 1'b0;
      step();
      step();
      check_b("pkt_held_valid", bus.flit_valid, 1'b1);
      check_w("pkt_held_data", bus.flit_data, 128'hB000);
      bus.flit_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_w("pkt_data", bus.flit_data, 128'hB000 + 128'(i));
         check_w("pkt_dest", 128'(bus.flit_dest), 128'(2));
         check_b("pkt_head", bus.flit_is_head, (i == 0));
         check_b("pkt_tail", bus.flit_is_tail, (i == 3));
         step();
         check_b("pkt_credit", bus.credit_out, 1'b1);
      end
      check_b("pkt_empty", bus.flit_valid, 1'b0);
      step();
      check_b("pkt_credit_end", bus.credit_out, 1'b0);

      // Full buffer with same-cycle dequeue and write
      bus.flit_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(128'hC000 + 128'(i), 3'd1, 1'b1);
         step();
      end
      send(128'hC004, 3'd1, 1'b1);
      bus.flit_ready = 1'b1;
      step();
      bus.send_in    = 1'b0;
      bus.flit_ready = 1'b0;
      check_w("full_sim_data", bus.flit_data, 128'hC001);
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
      check_b("full_sim_no_ovf", overflow_err, 1'b0);
`endif

      // Overflow: still full, send with no dequeue is dropped
      send(128'hC005, 3'd1, 1'b1);
      step();
      bus.send_in = 1'b0;
      step();
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
      check_b("ovf_set", overflow_err, 1'b1);
`endif
      check_w("ovf_head_data", bus.flit_data, 128'hC001);
      bus.flit_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         check_b("ovf_drain_valid", bus.flit_valid, 1'b1);
         check_w("ovf_drain_data", bus.flit_data, 128'hC000 + 128'(i));
         step();
      end
      check_b("ovf_dropped", bus.flit_valid, 1'b0);
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
      check_b("ovf_sticky", overflow_err, 1'b1);
`endif
      bus.flit_ready = 1'b0;
      step();
      step();

      // Random stream of 1000 flits under an upstream credit model
      credits = DEPTH;
      sent = 0;
      deq_n = 0;
      cred_n = 0;
      for (int cyc = 0; cyc < 8000 && sent < 1000; cyc++) begin
         if (bus.credit_out) begin
            credits++;
            cred_n++;
         end
         bus.flit_ready = ($urandom_range(0, 3) != 0);
         check_b("stream_valid", bus.flit_valid, (exp_q.size() != 0));
         if (bus.flit_valid && bus.flit_ready && exp_q.size() != 0) begin
            check_w("stream_data", bus.flit_data, exp_q.pop_front());
            deq_n++;
         end
         do_send = (credits > 0) && ($urandom_range(0, 3) != 0);
         if (do_send) begin
            d = {$urandom(), $urandom(), $urandom(), 32'(sent)};
            send(d, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            exp_q.push_back(d);
            credits--;
            sent++;
         end else begin
            bus.send_in = 1'b0;
         end
         step();
      end
      bus.send_in    = 1'b0;
      bus.flit_ready = 1'b1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (bus.credit_out) begin
            credits++;
            cred_n++;
         end
         if (bus.flit_valid && exp_q.size() != 0) begin
            check_w("drain_data", bus.flit_data, exp_q.pop_front());
            deq_n++;
         end
         step();
      end
      check_w("stream_sent", 128'(sent), 128'(1000));
      check_w("stream_leftover", 128'(exp_q.size()), 128'(0));
      check_w("stream_dequeued", 128'(deq_n), 128'(1000));
      check_w("stream_credits_ret", 128'(cred_n), 128'(1000));
      check_w("stream_credit_bal", 128'(credits), 128'(DEPTH));
      check_b("stream_empty", bus.flit_valid, 1'b0);

      // Reset in the middle of a packet
      bus.flit_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(128'hD000 + 128'(i), 3'd3, (i == 3));
         step();
      end
      bus.send_in    = 1'b0;
      bus.flit_ready = 1'b1;
      step();
      step();
      bus.flit_ready = 1'b0;
      check_w("mid_data", bus.flit_data, 128'hD002);
      check_b("mid_body", bus.flit_is_head, 1'b0);
      check_b("mid_credit", bus.credit_out, 1'b1);
      rst_n = 1'b0;
      #1;
      check_b("mrst_valid", bus.flit_valid, 1'b0);
      check_b("mrst_head", bus.flit_is_head, 1'b0);
      check_b("mrst_credit", bus.credit_out, 1'b0);
`ifdef NOC_INBUF_OVERFLOW_CHECK_EN
      check_b("mrst_ovf", overflow_err, 1'b0);
`endif
      step();
      step();
      rst_n = 1'b1;
      step();
      check_b("post_rst_empty", bus.flit_valid, 1'b0);
      send(128'hE009, 3'd6, 1'b0);
      step();
      bus.send_in = 1'b0;
      check_b("post_rst_valid", bus.flit_valid, 1'b1);
      check_b("post_rst_head", bus.flit_is_head, 1'b1);
      check_w("post_rst_dest", 128'(bus.flit_dest), 128'(6));
      check_w("post_rst_data", bus.flit_data, 128'hE009);
      check_b("post_rst_credit", bus.credit_out, 1'b0);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
